// File: rtl/fmap_uart_dumper.sv
// Reads a window of fmap_bank and streams it to the UART transmit handshake
// as a frame: HEADER, {4'h0,label}, length data bytes, 8-bit additive checksum.
module fmap_uart_dumper #(
  parameter int          ADDR_W   = 15,
  parameter logic [7:0]  HEADER   = 8'hA5,
  parameter int          READ_LAT = 1
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_start,
  input  logic [ADDR_W-1:0] i_base_addr,
  input  logic [ADDR_W-1:0] i_length,
  input  logic [3:0]        i_label,
  output logic [ADDR_W-1:0] o_fbank_raddr,
  output logic              o_fbank_ren,
  input  logic [7:0]        i_fdata_r,
  output logic [7:0]        o_tdata,
  output logic              o_tdata_req,
  input  logic              i_tdata_ready,
  output logic              o_busy,
  output logic              o_done
);

  localparam logic [2:0] S_IDLE = 3'd0;
  localparam logic [2:0] S_HDR  = 3'd1;
  localparam logic [2:0] S_LBL  = 3'd2;
  localparam logic [2:0] S_RD   = 3'd3;
  localparam logic [2:0] S_WAIT = 3'd4;
  localparam logic [2:0] S_SEND = 3'd5;
  localparam logic [2:0] S_CSUM = 3'd6;
  localparam logic [2:0] S_FIN  = 3'd7;

  localparam logic [7:0] LAT_LAST = 8'(READ_LAT - 1);

  function automatic logic [7:0] f_csum_add(input logic [7:0] a, input logic [7:0] b);
    return a + b;
  endfunction

  logic [2:0]        r_state;
  logic [ADDR_W-1:0] r_ptr;
  logic [ADDR_W-1:0] r_cnt;
  logic [3:0]        r_label;
  logic [7:0]        r_csum;
  logic [7:0]        r_tdata;
  logic [7:0]        r_lat;
  logic              r_guard;
  logic              w_tx_state;
  logic              w_req;
  logic [7:0]        w_csum_nxt;

  // The request is gated by the live ready so it is never raised while the UART is busy;
  // r_guard blocks the cycle right after any request.
  assign w_tx_state = (r_state == S_HDR) || (r_state == S_LBL) ||
                      (r_state == S_SEND) || (r_state == S_CSUM);
  assign w_req      = w_tx_state && !r_guard && i_tdata_ready;
  assign w_csum_nxt = f_csum_add(r_csum, r_tdata);

  assign o_tdata_req   = w_req;
  assign o_tdata       = r_tdata;
  assign o_fbank_ren   = (r_state == S_RD);
  assign o_fbank_raddr = r_ptr;
  assign o_busy        = (r_state != S_IDLE);
  assign o_done        = (r_state == S_FIN);

  // Frame sequencer: latches the job, walks the read/transmit states, tracks checksum.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_ptr   <= {ADDR_W{1'b0}};
      r_cnt   <= {ADDR_W{1'b0}};
      r_label <= 4'h0;
      r_csum  <= 8'h00;
      r_tdata <= 8'h00;
      r_lat   <= 8'h00;
      r_guard <= 1'b0;
    end else begin
      r_guard <= w_req;
      case (r_state)
        S_IDLE: begin
          if (i_start) begin
            r_ptr   <= i_base_addr;
            r_cnt   <= i_length;
            r_label <= i_label;
            r_csum  <= 8'h00;
            r_tdata <= HEADER;
            r_state <= S_HDR;
          end
        end
        S_HDR: begin
          if (w_req) begin
            r_tdata <= {4'h0, r_label};
            r_state <= S_LBL;
          end
        end
        S_LBL: begin
          if (w_req) begin
            r_csum <= w_csum_nxt;
            if (r_cnt == {ADDR_W{1'b0}}) begin
              r_tdata <= w_csum_nxt;
              r_state <= S_CSUM;
            end else begin
              r_state <= S_RD;
            end
          end
        end
        S_RD: begin
          r_ptr   <= r_ptr + ADDR_W'(1);
          r_lat   <= 8'h00;
          r_state <= S_WAIT;
        end
        S_WAIT: begin
          if (r_lat == LAT_LAST) begin
            r_tdata <= i_fdata_r;
            r_state <= S_SEND;
          end else begin
            r_lat <= r_lat + 8'd1;
          end
        end
        S_SEND: begin
          if (w_req) begin
            r_csum <= w_csum_nxt;
            r_cnt  <= r_cnt - ADDR_W'(1);
            // Last data byte: the checksum byte is loaded while the guard cycle runs.
            if (r_cnt == ADDR_W'(1)) begin
              r_tdata <= w_csum_nxt;
              r_state <= S_CSUM;
            end else begin
              r_state <= S_RD;
            end
          end
        end
        S_CSUM: begin
          if (w_req) begin
            r_state <= S_FIN;
          end
        end
        S_FIN: begin
          r_state <= S_IDLE;
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase
    end
  end

endmodule
